pipelined_rca: RTL and testbench



---
 rtl/pipelined_rca_pkg.sv | 13 +
 rtl/fulladder.sv | 13 +
 rtl/pipelined_rca_chunk.sv | 28 ++
 rtl/pipelined_rca.sv | 124 ++++++++++++
 tb/tb_pipelined_rca.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_rca_pkg.sv
// Shared configuration helpers for the pipelined ripple-carry adder.
// Optional signed-overflow output is enabled with PIPELINED_RCA_OVF_EN.
package pipelined_rca_pkg;

   function automatic int chunk_width(input int width, input int stages);
      return (stages > 0) ? width / stages : width;
   endfunction

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (width % stages == 0);
   endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, the building block of every ripple chunk.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_rca_chunk.sv
// Combinational W-bit ripple-carry adder built from a chain of full adders.
module rca_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_bit
      fulladder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[W];

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit add/sub split into STAGES registered ripple chunks with a valid/ready stall.
// Define PIPELINED_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_RCA_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
      $error("pipelined_rca: STAGES must be >= 1 and divide WIDTH");
   end

   logic              advance;
   logic [WIDTH-1:0]  b_eff;
   logic              c0;
   logic [STAGES:1]   vld_pipe;

   // Global stall: every stage holds together, bubbles are not squeezed out.
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;
   assign b_eff    = sub ? ~b : b;
   assign c0       = sub | cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else if (advance) begin
         vld_pipe[1] <= in_valid;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   assign out_valid = vld_pipe[STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO = (k + 1) * CHUNK;
      localparam int IW = WIDTH - k * CHUNK;

      // in_a/in_b: operand bits not yet consumed, current chunk at the bottom
      logic [IW-1:0]    in_a, in_b;
      logic             c_in, c_out;
      logic [CHUNK-1:0] s_c;
      logic [LO-1:0]    s_nxt, s_q;
      logic             c_q;

      if (k == 0) begin : g_src
         assign in_a  = a;
         assign in_b  = b_eff;
         assign c_in  = c0;
         assign s_nxt = s_c;
      end else begin : g_src
         assign in_a  = g_stg[k-1].g_skew.a_q;
         assign in_b  = g_stg[k-1].g_skew.b_q;
         assign c_in  = g_stg[k-1].c_q;
         assign s_nxt = {s_c, g_stg[k-1].s_q};
      end

      rca_chunk #(.W(CHUNK)) u_rca (
         .a    (in_a[CHUNK-1:0]),
         .b    (in_b[CHUNK-1:0]),
         .cin  (c_in),
         .sum  (s_c),
         .cout (c_out)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s_q <= '0;
            c_q <= 1'b0;
         end else if (advance) begin
            s_q <= s_nxt;
            c_q <= c_out;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [IW-CHUNK-1:0] a_q, b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= in_a[IW-1:CHUNK];
               b_q <= in_b[IW-1:CHUNK];
            end
         end
      end

`ifdef PIPELINED_RCA_OVF_EN
      // The last stage sees the operand MSBs, so overflow is resolved there.
      if (k == STAGES - 1) begin : g_ovf
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf <= 1'b0;
            else if (advance)
               ovf <= (in_a[CHUNK-1] == in_b[CHUNK-1]) & (s_c[CHUNK-1] != in_a[CHUNK-1]);
         end
      end
`endif
   end

   assign sum  = g_stg[STAGES-1].s_q;
   assign cout = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed vector table, stall/reset sequences, random traffic vs arithmetic model.
module tb_pipelined_rca;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [W-1:0] a, b, sum;
`ifdef PIPELINED_RCA_OVF_EN
   logic         ovf;
`endif

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   res_t exp_q[$];
   res_t mon_e;
   vec_t tv[9];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_ret = 0;

   pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_RCA_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Plain integer arithmetic: unsigned for sum/carry, signed range for overflow.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      res_t r;
      int   full, sfull;
      if (sb) begin
         full   = int'(x) - int'(y);
         sfull  = int'($signed(x)) - int'($signed(y));
         r.cout = (x >= y);
      end else begin
         full   = int'(x) + int'(y) + int'(ci);
         sfull  = int'($signed(x)) + int'($signed(y)) + int'(ci);
         r.cout = (full >= (1 << W));
      end
      r.sum = full[W-1:0];
      r.ovf = (sfull > 32767) || (sfull < -32768);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
   endtask

   // Scoreboard: retire before accept; in-flight ops vanish on reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            n_ret++;
            check("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("sb_sum", 32'(sum), 32'(mon_e.sum));
               check("sb_cout", 32'(cout), 32'(mon_e.cout));
`ifdef PIPELINED_RCA_OVF_EN
               check("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      end
   end

   always @(negedge rst_n) exp_q.delete();

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int           r0, k, lat, cnt;
      logic         acc;
      logic [15:0]  ov_seen, ov_exp;
      logic [W-1:0] hs, pa[5], pb[5];
      logic         hc;

      tv[0] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
      tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tv[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tv[5] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
      tv[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      tv[7] = '{16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
      tv[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      // Reset state
      idle();
      out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_cout", 32'(cout), 0);
`ifdef PIPELINED_RCA_OVF_EN
      check("rst_ovf", 32'(ovf), 0);
`endif
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      tick();
      check("rst_out_valid_after", 32'(out_valid), 0);

      // Directed vectors, one at a time, with latency measured from the accepting edge
      for (int i = 0; i < 9; i++) begin
         a = tv[i].a; b = tv[i].b; cin = tv[i].cin; sub = tv[i].sub;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
         check($sformatf("tv%0d_latency", i), 32'(lat), S);
         check($sformatf("tv%0d_sum", i), 32'(sum), 32'(tv[i].sum));
         check($sformatf("tv%0d_cout", i), 32'(cout), 32'(tv[i].cout));
`ifdef PIPELINED_RCA_OVF_EN
         check($sformatf("tv%0d_ovf", i), 32'(ovf), 32'(tv[i].ovf));
`endif
         tick();
      end

      // Back-to-back: 8 ops on consecutive cycles, results on consecutive cycles
      r0 = n_ret;
      ov_seen = '0;
      ov_exp = '0;
      for (int j = 0; j < 16; j++) ov_exp[j] = (j >= S - 1) && (j < S - 1 + 8);
      for (int j = 0; j < 14; j++) begin
         if (j < 8) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
         end else idle();
         tick();
         ov_seen[j] = out_valid;
      end
      check("b2b_valid_pattern", 32'(ov_seen), 32'(ov_exp));
      check("b2b_count", 32'(n_ret - r0), 8);

      // Backpressure: consumer stalls 6 cycles while 5 ops are offered
      r0 = n_ret;
      for (int j = 0; j < 5; j++) begin
         pa[j] = 16'($urandom); pb[j] = 16'($urandom);
      end
      out_ready = 1'b0;
      k = 0;
      hs = '0; hc = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (k < 5) begin
            a = pa[k]; b = pb[k]; cin = 1'b0; sub = k[0]; in_valid = 1'b1;
         end else in_valid = 1'b0;
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
         if (j == 3) begin
            hs = sum; hc = cout;
         end else if (j > 3) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_sum", 32'(sum), 32'(hs));
            check("bp_hold_cout", 32'(cout), 32'(hc));
         end
      end
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_accepted_while_stalled", 32'(k), S);
      out_ready = 1'b1;
      cnt = 0;
      while ((k < 5 || exp_q.size() != 0 || out_valid) && cnt < 40) begin
         if (k < 5) begin
            a = pa[k]; b = pb[k]; cin = 1'b0; sub = k[0]; in_valid = 1'b1;
         end else idle();
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) k++;
         cnt++;
      end
      idle();
      check("bp_drain_in_time", 32'(cnt < 40), 1);
      check("bp_retired", 32'(n_ret - r0), 5);

      // Reset mid-flight: one result waiting at the output, three ops behind it
      out_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         a = 16'h1111 * 16'(j + 1); b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         tick();
      end
      idle();
      check("rf_pre_valid", 32'(out_valid), 1);
      check("rf_pre_sum", 32'(sum), 32'h3333);
      #2;
      rst_n = 1'b0;
      #1;
      check("rf_async_valid", 32'(out_valid), 0);
      check("rf_async_sum", 32'(sum), 0);
      check("rf_async_cout", 32'(cout), 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         tick();
         if (out_valid) cnt++;
      end
      check("rf_no_stale_output", 32'(cnt), 0);

      // Random traffic: producer keeps an op until accepted, consumer stalls randomly
      in_valid = 1'b0;
      for (int j = 0; j < 400; j++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
         end
         out_ready = 1'($urandom);
         #1;
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      idle();
      out_ready = 1'b1;
      repeat (S + 2) tick();
      check("final_sb_empty", 32'(exp_q.size()), 0);
      check("final_out_valid", 32'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
